// File: rtl/frame_link_arbiter_if.sv
// Bundle of the frame request, outgoing link, confirm and result signals
// shared between the frame sources/far end and the frame link arbiter.
interface frame_link_arbiter_if #(
    parameter int NUM_CH      = 2,
    parameter int FRAME_BYTES = 87,
    parameter int MAX_RETRY   = 3
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [NUM_CH*FRAME_BYTES*8-1:0] fin;
    logic [NUM_CH-1:0]               fin_valid;
    logic [NUM_CH-1:0]               fin_ready;
    logic [NUM_CH-1:0]               semafor;
    logic [FRAME_BYTES*8-1:0]        fout;
    logic                            fout_valid;
    logic [CHW-1:0]                  fout_ch;
    logic [7:0]                      conf_code;
    logic                            conf_valid;
    logic                            result_valid;
    logic [CHW-1:0]                  result_ch;
    logic [1:0]                      result_code;
    logic [RCW-1:0]                  retry_cnt;

    // Sources and far end: drive frames, requests and confirm codes.
    modport master (
        output fin, fin_valid, conf_code, conf_valid,
        input  fin_ready, semafor, fout, fout_valid, fout_ch,
               result_valid, result_ch, result_code, retry_cnt
    );

    // Arbiter side.
    modport slave (
        input  fin, fin_valid, conf_code, conf_valid,
        output fin_ready, semafor, fout, fout_valid, fout_ch,
               result_valid, result_ch, result_code, retry_cnt
    );
endinterface

// File: rtl/frame_link_arbiter.sv
// Round-robin arbiter that hands one shared frame link to NUM_CH sources,
// sends the captured frame, waits for a confirm code and retransmits on
// ERROR or timeout until the retry budget is spent.
module frame_link_arbiter #(
    parameter int         NUM_CH      = 2,
    parameter int         FRAME_BYTES = 87,
    parameter int         MAX_RETRY   = 3,
    parameter int         ACK_TIMEOUT = 4096,
    parameter logic [7:0] OKAY        = 8'h05,
    parameter logic [7:0] ERROR       = 8'h04,
    parameter logic [7:0] FATAL_ERROR = 8'h08
) (
    input logic                clk,
    input logic                rst,
    frame_link_arbiter_if.slave link
);
    localparam int FW  = FRAME_BYTES * 8;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW1 = CHW + 1;
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_ERR     = 2'b01;
    localparam logic [1:0] RES_FATAL   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_ACK, RESULT} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    owner_q, owner_d;
    logic [CHW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RCW-1:0]    retry_q, retry_d;
    logic [FW-1:0]     fout_q, fout_d;
    logic [NUM_CH-1:0] semafor_q, semafor_d;
    logic [1:0]        result_code_q, result_code_d;

    logic              req_any;
    logic [CHW-1:0]    req_idx;
    logic [CW1-1:0]    cand;

    // Register all state; reset drops any transaction in flight without a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            fout_q        <= '0;
            semafor_q     <= '0;
            result_code_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            fout_q        <= fout_d;
            semafor_q     <= semafor_d;
            result_code_q <= result_code_d;
        end
    end

    // Find the first requesting channel scanning upward from rr_ptr with wrap.
    always_comb begin
        req_any = 1'b0;
        req_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + CW1'(i);
            if (cand >= CW1'(NUM_CH)) begin
                cand = cand - CW1'(NUM_CH);
            end
            if (!req_any && link.fin_valid[cand[CHW-1:0]]) begin
                req_any = 1'b1;
                req_idx = cand[CHW-1:0];
            end
        end
    end

    // Transaction sequencing plus the datapath updates tied to each state.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        fout_d        = fout_q;
        semafor_d     = semafor_q;
        result_code_d = result_code_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d   = req_idx;
                    semafor_d = NUM_CH'(1) << req_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (owner_q == CHW'(c)) begin
                        fout_d = link.fin[c*FW +: FW];
                    end
                end
                retry_d = '0;
                state_d = SEND;
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                timer_d = timer_q + TW'(1);
                if (link.conf_valid && link.conf_code == OKAY) begin
                    result_code_d = RES_OK;
                    state_d       = RESULT;
                end else if (link.conf_valid && link.conf_code == FATAL_ERROR) begin
                    result_code_d = RES_FATAL;
                    state_d       = RESULT;
                end else if (link.conf_valid && link.conf_code == ERROR) begin
                    if (retry_q < RCW'(MAX_RETRY)) begin
                        retry_d = retry_q + RCW'(1);
                        state_d = SEND;
                    end else begin
                        result_code_d = RES_ERR;
                        state_d       = RESULT;
                    end
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < RCW'(MAX_RETRY)) begin
                        retry_d = retry_q + RCW'(1);
                        state_d = SEND;
                    end else begin
                        result_code_d = RES_TIMEOUT;
                        state_d       = RESULT;
                    end
                end
            end
            RESULT: begin
                rr_ptr_d  = (owner_q == CHW'(NUM_CH - 1)) ? '0 : owner_q + CHW'(1);
                semafor_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded pulses plus the held registered outputs.
    always_comb begin
        link.fin_ready    = (state_q == GRANT) ? (NUM_CH'(1) << owner_q) : '0;
        link.fout_valid   = (state_q == SEND);
        link.result_valid = (state_q == RESULT);
        link.result_ch    = (state_q == RESULT) ? owner_q : '0;
        link.semafor      = semafor_q;
        link.fout         = fout_q;
        link.fout_ch      = owner_q;
        link.result_code  = result_code_q;
        link.retry_cnt    = retry_q;
    end
endmodule

// File: doc/frame_link_arbiter.md
Name: frame_link_arbiter

Overview:
- Generalised successor to the fixed two-interface semaphore pairing: arbitrates NUM_CH frame sources onto one shared outgoing frame link.
- Source examples: plain/secret interfaces and the core.
- Grants the link round-robin, drives a one-hot semaphore, sends the latched frame, then waits for a confirm code (OKAY/ERROR/FATAL_ERROR).
- Retransmits on ERROR or timeout up to MAX_RETRY, then reports a per-transaction result.

Parameters:
- NUM_CH, 2: number of requesting channels (>=2).
- FRAME_BYTES, 87: frame width in bytes (preamble 7 + data 64 + CRC 4 + nonce 12).
- MAX_RETRY, 3: retransmissions allowed after the first send.
- ACK_TIMEOUT, 4096: cycles spent in WAIT_ACK before a timeout (>=2).
- OKAY, 8'h05: success confirm code.
- ERROR, 8'h04: retryable error confirm code.
- FATAL_ERROR, 8'h08: non-retryable confirm code.
- CHW (local), max(1, clog2(NUM_CH)): channel index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fin  in  NUM_CH*FRAME_BYTES*8  flattened frames; channel c occupies bits [c*FRAME_BYTES*8 +: FRAME_BYTES*8].
- fin_valid  in  NUM_CH  per-channel send request.
- fin_ready  out  NUM_CH  one-hot, 1-cycle pulse in the cycle the channel's frame is captured.
- semafor  out  NUM_CH  one-hot link owner; all zero when idle.
- fout  out  FRAME_BYTES*8  latched frame.
- fout_valid  out  1  1-cycle pulse per transmission, including each retry.
- fout_ch  out  CHW  index of the owning channel.
- conf_code  in  8  confirm code from the far end.
- conf_valid  in  1  conf_code qualifier.
- result_valid  out  1  1-cycle end-of-transaction pulse.
- result_ch  out  CHW  channel of the finished transaction.
- result_code  out  2  00 ok, 01 error retries exhausted, 10 fatal, 11 timeout retries exhausted.
- retry_cnt  out  clog2(MAX_RETRY+1)  retries used in the current transaction.

Behaviour:
- Reset:
  - State IDLE, rr_ptr=0, timer=0, retry_cnt=0.
  - All outputs 0, including fout and semafor.
- Reset mid-transaction aborts immediately: no result_valid pulse, semafor cleared on the next edge.
- FSM states: IDLE, GRANT, SEND, WAIT_ACK, RESULT.
- IDLE, arbitration:
  - If any fin_valid bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - Register the owner, set semafor one-hot, go to GRANT.
  - Nothing set: stay in IDLE.
- GRANT:
  - fin_ready[owner]=1.
  - fout <= owner slice of fin, captured regardless of the current fin_valid.
  - retry_cnt<=0, go to SEND.
- SEND: fout_valid=1 for exactly one cycle, timer<=0, go to WAIT_ACK.
- WAIT_ACK: timer increments every cycle; conf_valid is evaluated before the timeout.
  - conf_valid and conf_code==OKAY: result 00 → RESULT.
  - conf_valid and conf_code==FATAL_ERROR: result 10 → RESULT.
  - conf_valid and conf_code==ERROR:
    - retry_cnt<MAX_RETRY: retry_cnt++, → SEND.
    - Otherwise: result 01 → RESULT.
  - conf_valid with any other code: ignored, timer keeps running.
  - timer==ACK_TIMEOUT-1 with no conf_valid:
    - retry_cnt<MAX_RETRY: retry_cnt++, → SEND.
    - Otherwise: result 11 → RESULT.
  - conf_valid in the same cycle as the timeout: conf_valid wins.
- RESULT:
  - result_valid=1, result_ch=owner, result_code held.
  - rr_ptr <= (owner+1) mod NUM_CH.
  - semafor cleared at the transition to IDLE.
- Hold rules:
  - fout, fout_ch and result_code hold their values until next overwritten.
  - semafor is high from the GRANT cycle through the RESULT cycle inclusive.
- conf_valid outside WAIT_ACK is ignored.
- Timing:
  - Best-case latency: fin_valid sampled in IDLE at cycle t → fin_ready at t+1 → fout_valid at t+2.
  - Minimum OKAY round trip: conf at t+3 → result_valid at t+4.
  - Back-to-back: the next grant is decided in the IDLE cycle after RESULT.

Test Plan:
- Single request: fin_valid=01, ch0 frame bytes 0x00..0x56, OKAY two cycles after fout_valid → fin_ready=01 at t+1, fout_valid at t+2 with fout equal to the ch0 frame, result_valid with ch=0, code=00; semafor=01 only during the transaction.
- Fairness: fin_valid=11 held for four transactions, all OKAY → grant order 0,1,0,1; fin_ready and semafor never multi-hot.
- Retry exhaustion: MAX_RETRY=3, always answer ERROR → 4 fout_valid pulses with identical fout, retry_cnt reaches 3, result_code=01.
- Fatal and timeout:
  - FATAL_ERROR on the first reply → single send, result_code=10.
  - No reply at all, ACK_TIMEOUT=16 → sends spaced 17 cycles apart, 4 sends total, result_code=11.
- Boundary: OKAY exactly in the timeout cycle → result_code=00 with no resend; conf_valid=1 in IDLE → no effect.
- Reset mid-WAIT_ACK: no result_valid; all outputs 0 the cycle after; a fresh request is granted from ch0.
